// File: rtl/sap_pkg.sv
// Shared SAP definitions: default bus/opcode widths, instruction-register
// state encoding and the opcode constants the controller and IR agree on.
package sap_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;

  // Opcodes at or above this value carry a second (operand) word.
  localparam logic [OPC_W-1:0] LONG_OPC_BASE = 4'hC;
  // Halt instruction; only special when halt detection is compiled in.
  localparam logic [OPC_W-1:0] HLT_OPC       = 4'hF;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_OPND = 2'd1,
    FULL      = 2'd2
  } ir_state_t;

endpackage

// File: rtl/tri_bus_drv.sv
// Parametrised tri-state driver: puts data on the bus while en is high,
// otherwise releases it to high-Z.
module tri_bus_drv #(
  parameter int W = 8
) (
  input  logic [W-1:0] data,
  input  logic         en,
  inout  wire  [W-1:0] bus
);

  // Drive or release the shared bus.
  assign bus = en ? data : {W{1'bz}};

endmodule

// File: rtl/iregfile_seq.sv
// Instruction register with one/two-word fetch. Captures instruction words
// from the shared data bus, splits opcode/operand and drives the operand
// back onto the bus on request. Optional halt detection is compiled in with
// the IREGFILE_HALT_DETECT_EN macro (adds the `halted` output).
module iregfile_seq #(
  parameter int                DATA_W        = sap_pkg::DATA_W,
  parameter int                OPC_W         = sap_pkg::OPC_W,
  parameter logic [OPC_W-1:0]  LONG_OPC_BASE = sap_pkg::LONG_OPC_BASE
`ifdef IREGFILE_HALT_DETECT_EN
  ,
  parameter logic [OPC_W-1:0]  HLT_OPC       = sap_pkg::HLT_OPC
`endif
) (
  input  logic              clk,
  input  logic              clr,
  inout  wire  [DATA_W-1:0] dbus,
  input  logic              n_load,
  input  logic              n_en,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] operand,
  output logic              instr_valid,
  output logic              long_instr,
  output logic              busy,
  output logic              bus_conflict
`ifdef IREGFILE_HALT_DETECT_EN
  ,
  output logic              halted
`endif
);

  import sap_pkg::*;

  ir_state_t          state;
  logic [OPC_W-1:0]   word_opc;
  logic               word_long;
  logic               load_ok;
  logic               drive_en;

  // Decode the word currently on the bus as a potential first word.
  assign word_opc  = dbus[DATA_W-1 -: OPC_W];
  assign word_long = (word_opc >= LONG_OPC_BASE);

  // A halted IR ignores loads but still serves operand reads.
`ifdef IREGFILE_HALT_DETECT_EN
  assign load_ok = !n_load && !halted;
`else
  assign load_ok = !n_load;
`endif

  // Never drive while loading: the bus belongs to whoever is writing us.
  assign drive_en = !n_en && instr_valid && n_load;

  tri_bus_drv #(.W(DATA_W)) u_drv (
    .data (operand),
    .en   (drive_en),
    .bus  (dbus)
  );

  // Fetch FSM with registered decode outputs and sticky conflict flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= EMPTY;
      opcode       <= '0;
      operand      <= '0;
      instr_valid  <= 1'b0;
      long_instr   <= 1'b0;
      busy         <= 1'b0;
      bus_conflict <= 1'b0;
`ifdef IREGFILE_HALT_DETECT_EN
      halted       <= 1'b0;
`endif
    end else begin
      if (!n_load && !n_en) bus_conflict <= 1'b1;
      if (load_ok) begin
        case (state)
          EMPTY, FULL: begin
            opcode <= word_opc;
`ifdef IREGFILE_HALT_DETECT_EN
            if (word_opc == HLT_OPC) halted <= 1'b1;
`endif
            if (!word_long) begin
              operand     <= {{OPC_W{1'b0}}, dbus[DATA_W-OPC_W-1:0]};
              long_instr  <= 1'b0;
              state       <= FULL;
              instr_valid <= 1'b1;
              busy        <= 1'b0;
            end else begin
              operand     <= '0;
              long_instr  <= 1'b1;
              state       <= WAIT_OPND;
              instr_valid <= 1'b0;
              busy        <= 1'b1;
            end
          end
          WAIT_OPND: begin
            operand     <= dbus;
            state       <= FULL;
            instr_valid <= 1'b1;
            busy        <= 1'b0;
          end
          default: begin
            state       <= EMPTY;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iregfile_seq.sv
// Scoreboard bench for iregfile_seq: a word-list reference model predicts
// outputs and bus contents each cycle; a negedge monitor compares them.
module tb_iregfile_seq;

  logic       clk = 1'b0;
  logic       clr, n_load, n_en, tb_oe;
  logic [7:0] tb_drv;
  wire  [7:0] dbus;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic       instr_valid, long_instr, busy, bus_conflict;
`ifdef IREGFILE_HALT_DETECT_EN
  logic       halted;
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  // External bus master plus weak pull-ups so a released bus reads all ones.
  assign dbus = tb_oe ? tb_drv : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (dbus[i]);
  end

  iregfile_seq dut (
    .clk          (clk),
    .clr          (clr),
    .dbus         (dbus),
    .n_load       (n_load),
    .n_en         (n_en),
    .opcode       (opcode),
    .operand      (operand),
    .instr_valid  (instr_valid),
    .long_instr   (long_instr),
    .busy         (busy),
    .bus_conflict (bus_conflict)
`ifdef IREGFILE_HALT_DETECT_EN
    ,
    .halted       (halted)
`endif
  );

  typedef struct {
    logic [3:0] opc;
    logic [7:0] opnd;
    logic       v, lg, bsy, cf, hl;
    logic [7:0] bus;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: the words of the current instruction, in fetch order.
  logic [7:0] words[$];
  bit         m_conflict, m_halted;
  bit         p_clr, p_nl, p_ne;
  logic [7:0] p_data;

  function automatic int need(logic [7:0] w0);
    return (w0[7:4] >= 4'hC) ? 2 : 1;
  endfunction

  function automatic bit m_valid();
    return words.size() > 0 && words.size() == need(words[0]);
  endfunction

  function automatic bit m_busy();
    return words.size() == 1 && need(words[0]) == 2;
  endfunction

  function automatic logic [7:0] m_opnd();
    if (words.size() == 0) return 8'h00;
    if (words.size() == 2) return words[1];
    if (need(words[0]) == 2) return 8'h00;
    return {4'h0, words[0][3:0]};
  endfunction

  task automatic model_reset();
    words.delete();
    m_conflict = 0;
    m_halted   = 0;
  endtask

  task automatic model_edge();
    if (p_clr) begin
      model_reset();
    end else begin
      if (!p_nl && !p_ne) m_conflict = 1;
      if (!p_nl && !m_halted) begin
        if (m_busy()) words.push_back(p_data);
        else begin
          words.delete();
          words.push_back(p_data);
          if (HALT_EN && p_data[7:4] == 4'hF) m_halted = 1;
        end
      end
    end
  endtask

  task automatic step(input bit c, input bit nl, input bit ne, input logic [7:0] d);
    exp_t e;
    @(posedge clk);
    model_edge();
    #2;
    clr = c; n_load = nl; n_en = ne; tb_oe = !nl; tb_drv = d;
    if (c) model_reset();
    p_clr = c; p_nl = nl; p_ne = ne; p_data = d;
    e.opc  = (words.size() > 0) ? words[0][7:4] : 4'h0;
    e.opnd = m_opnd();
    e.v    = m_valid();
    e.lg   = words.size() > 0 && need(words[0]) == 2;
    e.bsy  = m_busy();
    e.cf   = m_conflict;
    e.hl   = m_halted;
    if (!ne && e.v && nl) e.bus = e.opnd;
    else if (!nl)         e.bus = d;
    else                  e.bus = 8'hFF;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // Monitor: compare DUT against the oldest prediction mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("opcode",       {4'h0, opcode},       {4'h0, e.opc});
      chk("operand",      operand,              e.opnd);
      chk("instr_valid",  {7'h0, instr_valid},  {7'h0, e.v});
      chk("long_instr",   {7'h0, long_instr},   {7'h0, e.lg});
      chk("busy",         {7'h0, busy},         {7'h0, e.bsy});
      chk("bus_conflict", {7'h0, bus_conflict}, {7'h0, e.cf});
      chk("dbus",         dbus,                 e.bus);
`ifdef IREGFILE_HALT_DETECT_EN
      chk("halted",       {7'h0, halted},       {7'h0, e.hl});
`endif
    end
  end

  initial begin
    clr = 1; n_load = 1; n_en = 1; tb_oe = 0; tb_drv = 8'h00;
    p_clr = 1; p_nl = 1; p_ne = 1; p_data = 8'h00;
    model_reset();

    step(1, 1, 1, 8'h00);
    step(0, 1, 0, 8'h00);               // n_en with nothing held: released
    step(0, 0, 1, 8'h2B);               // short load
    step(0, 1, 0, 8'h00);               // read back 0B
    step(0, 1, 1, 8'h00);
    step(0, 0, 1, 8'hD0);               // long load, first word
    step(0, 0, 1, 8'h7E);               // operand word
    step(0, 1, 0, 8'h00);
    step(0, 1, 1, 8'h00);
    step(0, 0, 1, 8'hC0);               // long load aborted by clr
    step(1, 1, 1, 8'h00);
    step(0, 0, 1, 8'h31);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h45);               // load and enable together
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h12);
    step(0, 1, 1, 8'h00);
    step(1, 0, 1, 8'hA5);               // async clr mid-cycle while loading
    step(1, 0, 1, 8'hA5);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'hF0);               // halt opcode
    step(0, 0, 1, 8'h12);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h34);
    step(1, 1, 1, 8'h00);
    step(0, 0, 1, 8'h12);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 40) == 0, $urandom % 2, $urandom % 2, 8'($urandom));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
